econet_rx: RTL
==============

ECONET_RX -- requirements
Module: econet_rx

Interface
REQ-001 SHALL have ports (clock and reset first): econet_clk  in  1  bus bit clock, one line bit per rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: econet_data  in  1  line data as driven by the transmitter (inverted sense); internal bit d = ~econet_data.
REQ-004 SHALL have: rx_byte  out  8  last assembled byte, LSB received first.
REQ-005 SHALL have: byte_valid  out  1  one-cycle pulse, rx_byte newly updated.
REQ-006 SHALL have: frame_start  out  1  one-cycle pulse, coincident with byte_valid of the first byte of a frame.
REQ-007 SHALL have: frame_end  out  1  one-cycle pulse, closing flag of a good frame.
REQ-008 SHALL have: abort  out  1  one-cycle pulse, frame terminated abnormally.
REQ-009 SHALL have: receiving  out  1  high while inside a frame with at least one byte delivered.
REQ-010 Parameters: none.

Function
REQ-011 SHALL sample d on every rising econet_clk; all outputs registered, updated on the edge that samples the deciding bit.
REQ-012 SHALL keep ones counter (3 bits, saturating at 7): d=1 increments, d=0 clears after evaluation below.
REQ-013 States: HUNT, DATA; 3-bit bit counter bitcnt; 1-bit got_byte.
REQ-014 d=0 with ones==6 SHALL be a flag; d=0 with ones==5 SHALL be a stuffed zero, discarded (no shift, bitcnt unchanged); d=1 making ones==7 SHALL be an abort condition.
REQ-015 Every other bit in DATA SHALL be a data bit: shifted in at bit position bitcnt, bitcnt increments (wraps 7->0).
REQ-016 Data bit completing bitcnt==7 SHALL update rx_byte and pulse byte_valid; if got_byte==0 also pulse frame_start; then set got_byte.
REQ-017 HUNT: flag -> DATA with bitcnt=0, got_byte=0; all other bits ignored, no outputs.
REQ-018 DATA, flag with bitcnt==7 and got_byte==1 SHALL pulse frame_end; the 7 flag-prefix bits held in bitcnt 0..6 SHALL be discarded, never emitted.
REQ-019 DATA, flag with got_byte==0 (back-to-back/shared flags) SHALL re-sync silently: bitcnt=0, no pulse.
REQ-020 DATA, flag with got_byte==1 and bitcnt!=7 (non-octet frame) SHALL pulse abort instead of frame_end.
REQ-021 Any flag in DATA SHALL leave state DATA, bitcnt=0, got_byte=0 (closing flag may open next frame).
REQ-022 Abort condition SHALL go HUNT, bitcnt=0, got_byte=0; pulse abort only if state was DATA and got_byte==1.
REQ-023 Idle line (d=1 continuously) SHALL hold ones at 7 and state HUNT with no pulses.
REQ-024 receiving SHALL equal (state==DATA && got_byte), registered with other outputs.
REQ-025 frame_end, abort, byte_valid SHALL never assert on the same cycle as each other.

Reset
REQ-026 On reset: state HUNT, ones=7, bitcnt=0, got_byte=0, rx_byte=0x00, all pulse outputs and receiving 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial byte with no abort pulse; reception resumes only after a new flag.

Verification
REQ-028 Idle d=1 for 50 cycles, flag 0x7E, bytes 0x12,0x34, flag -> byte_valid twice (0x12, 0x34), frame_start with 0x12, frame_end once on closing flag's last bit, receiving high between.
REQ-029 Byte 0xFF after flag (wire 11111011 1, stuffed zero after fifth 1) -> single byte_valid with rx_byte=0xFF, stuffed bit not counted.
REQ-030 Flag, flag, flag, 0xA5, flag -> no pulses during repeated flags; one frame_start+byte_valid (0xA5), one frame_end.
REQ-031 Flag, 0x55, then seven 1s -> byte_valid 0x55, abort pulse on the seventh 1, state HUNT; following 0x66 with no flag ignored.
REQ-032 Flag, 0x81, 3 data bits, flag -> byte_valid 0x81 then abort (not frame_end) on closing flag.
REQ-033 Reset pulse after 4 bits of second byte -> no byte_valid/abort; outputs at reset values; next flag+0x3C frame received normally.

Source files
------------

// File: rtl/econet_rx.sv
// Econet serial receiver: HDLC-style flag/abort detection, zero-bit destuffing
// and LSB-first byte assembly, with per-frame start/end/abort pulses.
module econet_rx (
  input  logic       econet_clk,
  input  logic       reset,
  input  logic       econet_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_start,
  output logic       frame_end,
  output logic       abort,
  output logic       receiving
);

  typedef enum logic {HUNT, DATA} state_t;

  state_t     state_q, state_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       got_byte_q, got_byte_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       byte_valid_q, byte_valid_d;
  logic       frame_start_q, frame_start_d;
  logic       frame_end_q, frame_end_d;
  logic       abort_q, abort_d;
  logic       receiving_q, receiving_d;

  logic d;
  logic is_flag;
  logic is_stuff;
  logic is_abort;

  // The line is driven inverted; every decision below uses the true bit.
  assign d        = ~econet_data;
  assign is_flag  = ~d & (ones_q == 3'd6);
  assign is_stuff = ~d & (ones_q == 3'd5);
  assign is_abort = d & (ones_q >= 3'd6);

  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    got_byte_d    = got_byte_q;
    shift_d       = shift_q;
    rx_byte_d     = rx_byte_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    abort_d       = 1'b0;

    if (d) begin
      ones_d = (ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1;
    end else begin
      ones_d = 3'd0;
    end

    if (is_abort) begin
      abort_d    = (state_q == DATA) && got_byte_q;
      state_d    = HUNT;
      bitcnt_d   = 3'd0;
      got_byte_d = 1'b0;
    end else if (is_flag) begin
      // A closing flag is good only if its 7 prefix bits exactly filled bitcnt 0..6.
      if (state_q == DATA && got_byte_q) begin
        if (bitcnt_q == 3'd7) begin
          frame_end_d = 1'b1;
        end else begin
          abort_d = 1'b1;
        end
      end
      state_d    = DATA;
      bitcnt_d   = 3'd0;
      got_byte_d = 1'b0;
    end else if (!is_stuff && state_q == DATA) begin
      shift_d[bitcnt_q] = d;
      bitcnt_d          = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        rx_byte_d     = shift_d;
        byte_valid_d  = 1'b1;
        frame_start_d = ~got_byte_q;
        got_byte_d    = 1'b1;
      end
    end

    receiving_d = (state_d == DATA) && got_byte_d;
  end

  always_ff @(posedge econet_clk or posedge reset) begin
    if (reset) begin
      state_q       <= HUNT;
      ones_q        <= 3'd7;
      bitcnt_q      <= 3'd0;
      got_byte_q    <= 1'b0;
      shift_q       <= 8'h00;
      rx_byte_q     <= 8'h00;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      abort_q       <= 1'b0;
      receiving_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ones_q        <= ones_d;
      bitcnt_q      <= bitcnt_d;
      got_byte_q    <= got_byte_d;
      shift_q       <= shift_d;
      rx_byte_q     <= rx_byte_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      abort_q       <= abort_d;
      receiving_q   <= receiving_d;
    end
  end

  assign rx_byte     = rx_byte_q;
  assign byte_valid  = byte_valid_q;
  assign frame_start = frame_start_q;
  assign frame_end   = frame_end_q;
  assign abort       = abort_q;
  assign receiving   = receiving_q;

endmodule
